// File: rtl/elevator_pkg.sv
// Shared types and helpers for the 8-floor elevator controller.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;
  localparam int TIMER_W    = 32;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_e;

  // Collective scheduling: keep going the preferred way while work remains there.
  function automatic state_e pick_dir(input logic dir_pref, input logic above, input logic below);
    state_e result;
    result = ST_IDLE;
    if (dir_pref == DIR_UP) begin
      if (above)      result = ST_MOVE_UP;
      else if (below) result = ST_MOVE_DOWN;
    end else begin
      if (below)      result = ST_MOVE_DOWN;
      else if (above) result = ST_MOVE_UP;
    end
    return result;
  endfunction

endpackage

// File: rtl/elevator_call_register.sv
// Latches floor calls, merges them with live pulses and clears the floor being served.
module elevator_call_register
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req_i,
  input  logic [FLOOR_W-1:0]    floor_i,
  input  logic                  serve_i,
  input  logic [FLOOR_W-1:0]    serve_floor_i,
  output logic [NUM_FLOORS-1:0] req_o,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  here_o
);

  logic [NUM_FLOORS-1:0] pending_q;
  logic [NUM_FLOORS-1:0] pending_d;
  logic [NUM_FLOORS-1:0] req;
  logic [NUM_FLOORS-1:0] serve_mask;
  logic [NUM_FLOORS-1:0] above_bits;
  logic [NUM_FLOORS-1:0] below_bits;

  assign req = pending_q | call_req_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      assign serve_mask[gi] = serve_i && (serve_floor_i == FLOOR_W'(gi));
      assign above_bits[gi] = req[gi] && (FLOOR_W'(gi) > floor_i);
      assign below_bits[gi] = req[gi] && (FLOOR_W'(gi) < floor_i);
    end
  endgenerate

  assign pending_d = req & ~serve_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign req_o     = req;
  assign pending_o = pending_q;
  assign above_o   = |above_bits;
  assign below_o   = |below_bits;
  assign here_o    = req[floor_i];

endmodule

// File: rtl/elevator_controller.sv
// Elevator car sequencer: SCAN scheduling, travel/door timing, overload hold.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 50_000_000,
  parameter int unsigned DOOR_CYCLES   = 150_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  overload,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  door_open,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);

  state_e               state_q, state_d;
  logic [FLOOR_W-1:0]   floor_q, floor_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 dir_q, dir_d;
  logic                 door_open_q, moving_up_q, moving_down_q;

  logic [NUM_FLOORS-1:0] req;
  logic                  above, below, here;
  logic                  serve;
  logic [FLOOR_W-1:0]    serve_floor;
  logic [FLOOR_W-1:0]    next_floor;
  state_e                choice;

  elevator_call_register u_calls (
    .clk           (clk),
    .reset_n       (reset_n),
    .call_req_i    (call_req),
    .floor_i       (floor_q),
    .serve_i       (serve),
    .serve_floor_i (serve_floor),
    .req_o         (req),
    .pending_o     (pending),
    .above_o       (above),
    .below_o       (below),
    .here_o        (here)
  );

  assign choice     = pick_dir(dir_q, above, below);
  assign next_floor = (state_q == ST_MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    timer_d     = timer_q;
    dir_d       = dir_q;
    serve       = 1'b0;
    serve_floor = floor_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (here) begin
          state_d = ST_DOOR_OPEN;
          serve   = 1'b1;
        end else begin
          state_d = choice;
          if (choice == ST_MOVE_UP)   dir_d = DIR_UP;
          if (choice == ST_MOVE_DOWN) dir_d = DIR_DOWN;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (timer_q == TRAVEL_LAST) begin
          floor_d = next_floor;
          timer_d = '0;
          // Live pulses count here, so a call arriving on the arrival cycle still stops the car.
          if (req[next_floor]) begin
            state_d     = ST_DOOR_OPEN;
            serve       = 1'b1;
            serve_floor = next_floor;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_DOOR_OPEN: begin
        serve = 1'b1;
        if (call_req[floor_q]) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          if (!overload) begin
            state_d = choice;
            timer_d = '0;
            if (choice == ST_MOVE_UP)   dir_d = DIR_UP;
            if (choice == ST_MOVE_DOWN) dir_d = DIR_DOWN;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      floor_q       <= '0;
      timer_q       <= '0;
      dir_q         <= DIR_UP;
      door_open_q   <= 1'b0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      floor_q       <= floor_d;
      timer_q       <= timer_d;
      dir_q         <= dir_d;
      door_open_q   <= (state_d == ST_DOOR_OPEN);
      moving_up_q   <= (state_d == ST_MOVE_UP);
      moving_down_q <= (state_d == ST_MOVE_DOWN);
    end
  end

  assign floor       = floor_q;
  assign door_open   = door_open_q;
  assign moving_up   = moving_up_q;
  assign moving_down = moving_down_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
module tb_elevator_controller;

  logic       clk;
  logic       reset_n;
  logic [7:0] call_req;
  logic       overload;
  logic [2:0] floor;
  logic       door_open;
  logic       moving_up;
  logic       moving_down;
  logic [7:0] pending;
  logic [13:0] status;

  int checks   = 0;
  int failures = 0;

  elevator_controller #(
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .call_req    (call_req),
    .overload    (overload),
    .floor       (floor),
    .door_open   (door_open),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .pending     (pending)
  );

  assign status = {floor, door_open, moving_up, moving_down, pending};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] st(input logic [2:0] f, input logic d, input logic u,
                                     input logic dn, input logic [7:0] p);
    return {f, d, u, dn, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [13:0] exp);
    checks++;
    assert (status === exp) else begin
      failures++;
      $error("FAIL %s observed{floor,door,up,down,pending}=%h expected=%h", tag, status, exp);
    end
    $display("check %0d %s status=%h expected=%h", checks, tag, status, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    call_req = 8'h00;
    overload = 1'b0;
    ticks(2);
    chk("reset_state", st(3'd0, 0, 0, 0, 8'h00));
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", st(3'd0, 0, 0, 0, 8'h00));

    // Call at current floor: door 3 cycles then idle
    call_req = 8'h01;
    tick();
    call_req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk("t1_door_f0", st(3'd0, 1, 0, 0, 8'h00));
      tick();
    end
    chk("t1_idle_f0", st(3'd0, 0, 0, 0, 8'h00));

    // Floor 0 -> 3: 12 cycles moving, 4-cycle steps
    call_req = 8'h08;
    tick();
    call_req = 8'h00;
    for (int i = 0; i < 12; i++) begin
      chk("t2_travel_up", st(3'(i / 4), 0, 1, 0, 8'h08));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("t2_door_f3", st(3'd3, 1, 0, 0, 8'h00));
      tick();
    end
    chk("t2_idle_f3", st(3'd3, 0, 0, 0, 8'h00));

    // SCAN: toward 6, pick up 5 en route, then reverse to 1
    call_req = 8'h40;
    tick();
    chk("t3_start_up", st(3'd3, 0, 1, 0, 8'h40));
    call_req = 8'h20;
    tick();
    chk("t3_latch_5", st(3'd3, 0, 1, 0, 8'h60));
    call_req = 8'h02;
    tick();
    chk("t3_latch_1", st(3'd3, 0, 1, 0, 8'h62));
    call_req = 8'h00;
    ticks(5);
    chk("t3_pass_f4", st(3'd4, 0, 1, 0, 8'h62));
    tick();
    chk("t3_stop_f5", st(3'd5, 1, 0, 0, 8'h42));
    ticks(3);
    chk("t3_resume_up", st(3'd5, 0, 1, 0, 8'h42));
    ticks(4);
    chk("t3_stop_f6", st(3'd6, 1, 0, 0, 8'h02));
    ticks(2);
    chk("t3_door_f6_last", st(3'd6, 1, 0, 0, 8'h02));
    tick();
    chk("t3_reverse_down", st(3'd6, 0, 0, 1, 8'h02));
    ticks(19);
    chk("t3_pass_f2", st(3'd2, 0, 0, 1, 8'h02));
    tick();
    chk("t3_stop_f1", st(3'd1, 1, 0, 0, 8'h00));
    ticks(3);
    chk("t3_idle_f1", st(3'd1, 0, 0, 0, 8'h00));

    // Down preference wins a tie, then sweep up to the top floor
    call_req = 8'h81;
    tick();
    call_req = 8'h00;
    chk("t4_pref_down", st(3'd1, 0, 0, 1, 8'h81));
    ticks(4);
    chk("t4_stop_f0", st(3'd0, 1, 0, 0, 8'h80));
    ticks(3);
    chk("t4_turn_up", st(3'd0, 0, 1, 0, 8'h80));
    ticks(27);
    chk("t4_pass_f6", st(3'd6, 0, 1, 0, 8'h80));
    tick();
    chk("t4_stop_f7", st(3'd7, 1, 0, 0, 8'h00));
    ticks(3);
    chk("t4_idle_f7", st(3'd7, 0, 0, 0, 8'h00));

    // Overload hold at floor 2
    call_req = 8'h04;
    tick();
    call_req = 8'h00;
    chk("t5_start_down", st(3'd7, 0, 0, 1, 8'h04));
    ticks(20);
    chk("t5_door_f2", st(3'd2, 1, 0, 0, 8'h00));
    overload = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_overload_hold", st(3'd2, 1, 0, 0, 8'h00));
    end
    overload = 1'b0;
    tick();
    chk("t5_close_after_drop", st(3'd2, 0, 0, 0, 8'h00));

    // Dwell restart at floor 4
    call_req = 8'h10;
    tick();
    call_req = 8'h00;
    chk("t6_start_up", st(3'd2, 0, 1, 0, 8'h10));
    ticks(8);
    chk("t6_door_f4_c1", st(3'd4, 1, 0, 0, 8'h00));
    tick();
    chk("t6_door_f4_c2", st(3'd4, 1, 0, 0, 8'h00));
    call_req = 8'h10;
    tick();
    call_req = 8'h00;
    chk("t6_restart_c1", st(3'd4, 1, 0, 0, 8'h00));
    tick();
    chk("t6_restart_c2", st(3'd4, 1, 0, 0, 8'h00));
    tick();
    chk("t6_restart_c3", st(3'd4, 1, 0, 0, 8'h00));
    tick();
    chk("t6_idle_f4", st(3'd4, 0, 0, 0, 8'h00));

    // Reset while travelling 2 -> 3
    call_req = 8'h04;
    tick();
    call_req = 8'h00;
    chk("t7_start_down", st(3'd4, 0, 0, 1, 8'h04));
    ticks(8);
    chk("t7_door_f2", st(3'd2, 1, 0, 0, 8'h00));
    ticks(3);
    chk("t7_idle_f2", st(3'd2, 0, 0, 0, 8'h00));
    call_req = 8'h88;
    tick();
    call_req = 8'h00;
    chk("t7_start_up", st(3'd2, 0, 1, 0, 8'h88));
    ticks(2);
    chk("t7_mid_travel", st(3'd2, 0, 1, 0, 8'h88));
    reset_n = 1'b0;
    #1;
    chk("t7_async_reset", st(3'd0, 0, 0, 0, 8'h00));
    tick();
    chk("t7_held_in_reset", st(3'd0, 0, 0, 0, 8'h00));
    reset_n = 1'b1;
    ticks(3);
    chk("t7_calls_discarded", st(3'd0, 0, 0, 0, 8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
